// File: rtl/serial_signed_subtractor_pkg.sv
// Shared types and constants for the bit-serial signed subtractor.
// Holds the FSM encoding, operand width and bit-counter sizing.
package serial_signed_subtractor_pkg;

   localparam int WIDTH = 6;
   localparam int CNT_W = $clog2(WIDTH);

   // Bit whose carry-out is the carry into the MSB (first overflow term)
   localparam logic [CNT_W-1:0] C4_IDX = CNT_W'(WIDTH - 2);
   // Bit index of the MSB, the last bit processed
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/serial_signed_subtractor_fa_cell.sv
// Single-bit full-adder cell used by the serial subtractor.
// Purely combinational; the carry register lives in the parent.
module serial_fa_cell (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);

   assign sum  = a ^ b ^ cin;
   assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_signed_subtractor.sv
// Bit-serial 6-bit two's-complement subtractor, a - b = a + ~b + 1, LSB first.
// Optional SERIAL_ADD_MODE_EN adds an op port (0 = add, 1 = subtract).
module serial_signed_subtractor
   import serial_signed_subtractor_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADD_MODE_EN
   input  logic             op,
`endif
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             carry_out,
   output logic             overflow
);

   state_t           state;
   logic [WIDTH-1:0] sh_a;
   logic [WIDTH-1:0] sh_b;
   logic [WIDTH-2:0] res;
   logic [CNT_W-1:0] cnt;
   logic             c;
   logic             c4;

   logic             sub_sel;
   logic [WIDTH-1:0] ld_b;
   logic             sum_bit;
   logic             carry_nxt;

`ifdef SERIAL_ADD_MODE_EN
   assign sub_sel = op;
`else
   assign sub_sel = 1'b1;
`endif

   // Subtraction feeds the inverted subtrahend; the +1 comes from carry-in
   assign ld_b = sub_sel ? ~b : b;

   serial_fa_cell u_fa (
      .a    (sh_a[0]),
      .b    (sh_b[0]),
      .cin  (c),
      .sum  (sum_bit),
      .cout (carry_nxt)
   );

   // Control FSM, serial datapath and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         sh_a      <= '0;
         sh_b      <= '0;
         res       <= '0;
         cnt       <= '0;
         c         <= 1'b0;
         c4        <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         diff      <= '0;
         carry_out <= 1'b0;
         overflow  <= 1'b0;
      end else begin
         unique case (state)
            IDLE, DONE: begin
               done <= 1'b0;
               if (start) begin
                  sh_a  <= a;
                  sh_b  <= ld_b;
                  c     <= sub_sel;
                  c4    <= 1'b0;
                  cnt   <= '0;
                  busy  <= 1'b1;
                  state <= RUN;
               end else begin
                  state <= IDLE;
               end
            end
            RUN: begin
               res  <= {sum_bit, res[WIDTH-2:1]};
               sh_a <= sh_a >> 1;
               sh_b <= sh_b >> 1;
               c    <= carry_nxt;
               cnt  <= cnt + 1'b1;
               if (cnt == C4_IDX) begin
                  c4 <= carry_nxt;
               end
               if (cnt == LAST_IDX) begin
                  diff      <= {sum_bit, res};
                  carry_out <= carry_nxt;
                  overflow  <= c4 ^ carry_nxt;
                  busy      <= 1'b0;
                  done      <= 1'b1;
                  state     <= DONE;
               end
            end
            default: begin
               busy  <= 1'b0;
               done  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/serial_signed_subtractor.md
# serial_signed_subtractor

Bit-serial 6-bit two's-complement subtractor, the reverse-direction companion to the team's combinational ripple signed adder. It computes a − b as a + ~b + 1, processing one bit per clock, LSB first, through a single full-adder cell and a carry flip-flop. Carry-out and overflow semantics match the adder: overflow is the carry into bit 5 XOR the carry out of bit 5. It sits beside the combinational adder in the datapath and serves area-constrained paths that can accept multi-cycle latency.

## Interface
- `WIDTH`, 6, operand and result width in bits; fixed at 6 for this block, with the bit counter sized to match.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: request; sampled in IDLE or DONE.
- `a` input 6: minuend, two's complement; sampled when `start` is accepted.
- `b` input 6: subtrahend, two's complement; sampled when `start` is accepted.
- `op` input 1: present only with `SERIAL_ADD_MODE_EN`; 0 = add, 1 = subtract.
- `busy` output 1: high while bits are being processed (RUN).
- `done` output 1: one-cycle pulse when the result is valid.
- `diff` output 6: result; held until the next completion.
- `carry_out` output 1: carry out of bit 5 (1 = no borrow in subtract).
- `overflow` output 1: signed overflow, c4 XOR c5.

## Operation
- States: IDLE, RUN, DONE.
- IDLE, `start`=1:
  - latch `a` into shift register A and `b` (inverted for subtract) into shift register B;
  - carry FF ← 1 for subtract, 0 for add;
  - bit counter ← 0; go to RUN.
- RUN, per edge:
  - sum = A[0]^B[0]^c; carry FF ← majority(A[0], B[0], c);
  - shift sum into the result register from the MSB side; shift A and B right; counter++.
- Overflow capture:
  - at counter = 4, save the new carry (c5 input, i.e. carry into bit 5) as c4;
  - at counter = 5, the new carry is c5; go to DONE.
- DONE, single cycle:
  - drive `done`=1;
  - load `diff`, `carry_out`, and `overflow` = c4^c5 into the output registers;
  - with `start`=1, accept new operands immediately and go to RUN; otherwise go to IDLE.
- `start` in RUN is ignored: no re-latch, no error.
- Outputs `diff`/`carry_out`/`overflow` change only at completion. They remain stable through a subsequent RUN.
- Reset: state → IDLE; `busy`, `done`, `diff`, `carry_out`, `overflow` all → 0; shift registers, counter and carry FF → 0. A reset mid-RUN aborts the operation, and no `done` is issued.

## Timing
- Edge E0 samples `start` and enters RUN. Edges E1..E6 process bits 0..5.
- After E6, the outputs are updated and `done`=1 for exactly one cycle. `busy`=0 in that cycle.
- Latency: `done` asserts 6 edges after the accepting edge, then stays high for one cycle.
- `busy` is high for exactly 6 cycles per operation.
- Back-to-back: `start` held high gives one result every 7 cycles.
- All outputs are registered; there are no combinational input-to-output paths.

## Configuration
- `SERIAL_ADD_MODE_EN` defined:
  - the `op` port exists and is sampled with the operands;
  - `op`=0 loads B uninverted with carry-in 0 (add), and `carry_out`/`overflow` follow the adder's definitions;
  - `op`=1 subtracts.
- Undefined: no `op` port; the block always subtracts.

## Structure
- Shared package:
  - the state enum (IDLE/RUN/DONE);
  - `WIDTH` = 6;
  - the counter width;
  - the bit index of the c4 capture (`WIDTH`−2).
- One sub-module, `serial_fa_cell`: a combinational sum/carry cell. The carry FF lives in the parent.

## Test plan
- 5 − 3 (a=000101, b=000011, start) -> `done` 6 edges later; `diff`=000010, `carry_out`=1, `overflow`=0.
- 0 − 1 (a=000000, b=000001) -> `diff`=111111, `carry_out`=0, `overflow`=0.
- −32 − 1 (a=100000, b=000001) -> `diff`=011111, `carry_out`=1, `overflow`=1.
- 31 − (−32) (a=011111, b=100000) -> `diff`=111111, `carry_out`=0, `overflow`=1.
- Busy/reset:
  - `start` pulsed with new operands during RUN of 5 − 3 -> the result is still 000010, with exactly one `done`;
  - `rst` asserted at the 3rd RUN edge -> all outputs 0, no `done`, then IDLE.
- `SERIAL_ADD_MODE_EN`, `op`=0, a=011111, b=000001 -> `diff`=100000, `carry_out`=0, `overflow`=1. A back-to-back `start` held high yields `done` every 7 cycles.
